// File: rtl/jk_pkg.sv
// Shared jkff definitions: {j,k} operation codes, sequencer FSM states and
// the flip-flop next-state function.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Next q of a jkff given its current q and {j,k}
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic q_n;
    q_n = q;
    case ({j, k})
      JK_SET:    q_n = 1'b1;
      JK_RESET:  q_n = 1'b0;
      JK_TOGGLE: q_n = ~q;
      default:   q_n = q;
    endcase
    return q_n;
  endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake between a command source and jk_cmd_sequencer.
interface jk_cmd_sequencer_if #(
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_len, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; pushes while full and pops while empty are ignored.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op,len} commands and drives jkff j/k for len clocks each, tracking expected q.
// Optional q_obs/err self-check is built when JK_SEQ_CHECK_EN is defined.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_cmd_sequencer_if.slave      cmd,
  output logic                   j,
  output logic                   k,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   q_model
`ifdef JK_SEQ_CHECK_EN
  ,
  input  logic                   q_obs,
  output logic                   err
`endif
);
  localparam int unsigned FW = 2 + LEN_W;

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             j_d, k_d, done_d, q_model_d;
  logic             pop;
  logic             full, empty;
  logic [FW-1:0]    head;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .din   ({cmd.cmd_op, cmd.cmd_len}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign head_op       = head[FW-1:LEN_W];
  assign head_len      = head[LEN_W-1:0];
  assign cmd.cmd_ready = !full;
  assign busy          = (state_q == RUN) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
      done    <= 1'b0;
      q_model <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j       <= j_d;
      k       <= k_d;
      done    <= done_d;
      q_model <= q_model_d;
    end
  end

  // Zero-length commands are popped and dropped; a loaded command drives len clocks
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    j_d       = j;
    k_d       = k;
    pop       = 1'b0;
    q_model_d = jk_next(q_model, j, k);
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) begin
          pop = 1'b1;
          if (head_len != '0) begin
            {j_d, k_d} = head_op;
            rem_d      = head_len - LEN_W'(1);
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (rem_q != '0) begin
          rem_d = rem_q - LEN_W'(1);
        end else begin
          pop = !empty;
          if (!empty && head_len != '0) begin
            {j_d, k_d} = head_op;
            rem_d      = head_len - LEN_W'(1);
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == RUN) && (rem_d == '0);
  end

`ifdef JK_SEQ_CHECK_EN
  // Sticky mismatch flag between the observed flip-flop and the model
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err <= 1'b0;
    else if (q_obs != q_model)  err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed self-checking bench for jk_cmd_sequencer (DEPTH=4, LEN_W=4).
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  logic       clk;
  logic       rst;
  logic       j, k, done, busy, q_model;
  logic [2:0] fifo_cnt;
  int         n_tests;
  int         n_fail;

  jk_cmd_sequencer_if #(.LEN_W(4)) cmd_if ();

`ifdef JK_SEQ_CHECK_EN
  logic q_obs, err, jq, inj;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) jq <= 1'b0;
    else case ({j, k})
      2'b10:   jq <= 1'b1;
      2'b01:   jq <= 1'b0;
      2'b11:   jq <= ~jq;
      default: jq <= jq;
    endcase
  end
  assign q_obs = jq ^ inj;
`endif

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .j        (j),
    .k        (k),
    .done     (done),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .q_model  (q_model)
`ifdef JK_SEQ_CHECK_EN
    ,
    .q_obs    (q_obs),
    .err      (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] len);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = len;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic ej, input logic ek,
                         input logic ed, input logic eq);
    chk({tag, "_j"},    8'(j),       8'(ej));
    chk({tag, "_k"},    8'(k),       8'(ek));
    chk({tag, "_done"}, 8'(done),    8'(ed));
    chk({tag, "_q"},    8'(q_model), 8'(eq));
  endtask

  logic [1:0] b_op  [3];
  logic [3:0] b_len [3];
  logic [1:0] e_jk  [7];
  logic       e_d   [7];
  logic       e_q   [7];
  int         w;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_len   = 4'd0;
`ifdef JK_SEQ_CHECK_EN
    inj = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    chk_out("por", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("por_cnt",   8'(fifo_cnt),         8'd0);
    chk("por_ready", 8'(cmd_if.cmd_ready), 8'd1);
    chk("por_busy",  8'(busy),             8'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single SET/3
    push(JK_SET, 4'd3);
    chk("s_pushed_j",    8'(j),        8'd0);
    chk("s_pushed_busy", 8'(busy),     8'd1);
    chk("s_pushed_cnt",  8'(fifo_cnt), 8'd1);
    tick(); chk_out("s_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s_c1_cnt", 8'(fifo_cnt), 8'd0);
    tick(); chk_out("s_c2", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("s_c3", 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); chk_out("s_end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s_end_busy", 8'(busy), 8'd0);

    // Back-to-back SET/1, TOGGLE/4, RESET/2
    do_reset();
    b_op[0] = JK_SET;    b_len[0] = 4'd1;
    b_op[1] = JK_TOGGLE; b_len[1] = 4'd4;
    b_op[2] = JK_RESET;  b_len[2] = 4'd2;
    e_jk = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    e_d  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    e_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = b_op[i];
        cmd_if.cmd_len   = b_len[i];
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("b2b_c%0d_jk", i),   8'({j, k}), 8'(e_jk[i-1]));
        chk($sformatf("b2b_c%0d_done", i), 8'(done),   8'(e_d[i-1]));
        chk($sformatf("b2b_c%0d_q", i),    8'(q_model), 8'(e_q[i-1]));
      end
    end
    tick();
    chk_out("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_end_busy", 8'(busy), 8'd0);

    // FIFO full while a TOGGLE/15 holds off pops
    do_reset();
    push(JK_TOGGLE, 4'd15);
    for (int i = 0; i < 4; i++) push(JK_SET, 4'd1);
    chk("full_cnt",   8'(fifo_cnt),         8'd4);
    chk("full_ready", 8'(cmd_if.cmd_ready), 8'd0);
    chk("full_jk",    8'({j, k}),           8'd3);
    push(JK_RESET, 4'd5);
    chk("full_5th_cnt",   8'(fifo_cnt),         8'd4);
    chk("full_5th_ready", 8'(cmd_if.cmd_ready), 8'd0);
    w = 0;
    while (!cmd_if.cmd_ready && w < 30) begin
      tick();
      w++;
    end
    chk("full_wait",       8'(w),                8'd11);
    chk("full_ready_back", 8'(cmd_if.cmd_ready), 8'd1);
    chk("full_cnt_back",   8'(fifo_cnt),         8'd3);
    chk("full_busy",       8'(busy),             8'd1);

    // Asynchronous reset mid-command, checked before any clock edge
    rst = 1'b1;
    #1;
    chk_out("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_cnt",   8'(fifo_cnt),         8'd0);
    chk("arst_ready", 8'(cmd_if.cmd_ready), 8'd1);
    chk("arst_busy",  8'(busy),             8'd0);
    #1 rst = 1'b0;
    tick();

    // Zero-length HOLD discarded, then SET/2
    push(JK_HOLD, 4'd0);
    push(JK_SET, 4'd2);
    chk_out("z_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("z_drop_cnt",  8'(fifo_cnt), 8'd1);
    chk("z_drop_busy", 8'(busy),     8'd1);
    tick(); chk_out("z_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("z_c2", 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); chk_out("z_end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("z_end_busy", 8'(busy), 8'd0);

`ifdef JK_SEQ_CHECK_EN
    do_reset();
    push(JK_TOGGLE, 4'd5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("chk_ok%0d", i), 8'(err), 8'd0);
    end
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("chk_err_set", 8'(err), 8'd1);
    repeat (3) tick();
    chk("chk_err_sticky", 8'(err), 8'd1);
    rst = 1'b1;
    #1;
    chk("chk_err_rst", 8'(err), 8'd0);
    #1 rst = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
